// File: rtl/rm_lane_scheduler.sv
// rm_lane_scheduler: owns the pool of runtime-monitor lanes.
// Each newly enqueued monitored instruction is granted the lowest-index FREE
// lane in the same cycle. The lane captures the instruction's itype and PC and
// stays ACTIVE until the router releases it. A lane that stays ACTIVE too long
// is reclaimed by a per-lane age watchdog. In that case the lane spends one
// cycle in RECLAIM and signals a timeout pulse before it returns to FREE.
module rm_lane_scheduler #(
    parameter int NUM_LANES         = 7,
    parameter int NUM_MONITORED_INS = 2,
    parameter int TIMEOUT_CYCLES    = 1024,
    parameter int VLEN              = 64,
    localparam int ITYPE_W = (NUM_MONITORED_INS > 2) ? $clog2(NUM_MONITORED_INS) : 1,
    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int CNT_W   = $clog2(NUM_LANES + 1),
    localparam int AGE_W   = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           alloc_req_i,
    input  logic [ITYPE_W-1:0]             alloc_itype_i,
    input  logic [VLEN-1:0]                alloc_pc_i,
    output logic                           alloc_gnt_o,
    output logic [LANE_W-1:0]              alloc_lane_o,
    output logic                           alloc_full_o,
    input  logic [NUM_LANES-1:0]           lane_release_i,
    output logic [NUM_LANES-1:0]           lane_busy_o,
    output logic [NUM_LANES*ITYPE_W-1:0]   lane_itype_o,
    output logic [NUM_LANES*VLEN-1:0]      lane_pc_o,
    output logic [NUM_LANES-1:0]           lane_timeout_o,
    output logic [CNT_W-1:0]               occupancy_o
);

    typedef enum logic [1:0] {
        LANE_FREE    = 2'b00,
        LANE_ACTIVE  = 2'b01,
        LANE_RECLAIM = 2'b10
    } lane_state_e;

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES - 1);

    lane_state_e          state_r [NUM_LANES];
    logic [AGE_W-1:0]     age_r   [NUM_LANES];
    logic [ITYPE_W-1:0]   itype_r [NUM_LANES];
    logic [VLEN-1:0]      pc_r    [NUM_LANES];

    logic [NUM_LANES-1:0] free_r;
    logic [NUM_LANES-1:0] busy_r;
    logic [NUM_LANES-1:0] timeout_r;
    logic [CNT_W-1:0]     occ_r;
    logic                 full_r;

    logic                 gnt_s;
    logic [LANE_W-1:0]    gnt_lane_s;
    logic [NUM_LANES-1:0] gnt_vec_s;
    logic [NUM_LANES-1:0] expire_s;
    logic [NUM_LANES-1:0] busy_nxt_s;

    // Number of set bits in a lane vector. The result never exceeds NUM_LANES.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Grant selection, watchdog expiry, and the busy vector after the next edge.
    always_comb begin
        gnt_lane_s = '0;
        gnt_vec_s  = '0;
        expire_s   = '0;
        busy_nxt_s = '0;
        // The lowest-index free lane wins. The loop scans downward, so the last hit is the lowest index.
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (free_r[l]) begin
                gnt_lane_s = LANE_W'(l);
            end else begin
                gnt_lane_s = gnt_lane_s;
            end
        end
        gnt_s = alloc_req_i & ~flush_i & ~rst_i & (|free_r);
        if (!gnt_s) begin
            gnt_lane_s = '0;
        end else begin
            gnt_lane_s = gnt_lane_s;
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            gnt_vec_s[l]  = gnt_s & (gnt_lane_s == LANE_W'(l));
            expire_s[l]   = (state_r[l] == LANE_ACTIVE) & (age_r[l] == AGE_MAX)
                            & ~lane_release_i[l];
            // A lane is busy after the edge if it is granted now, or if it is ACTIVE and not released.
            // An ACTIVE lane that expires moves to RECLAIM, which still counts as busy.
            busy_nxt_s[l] = ~flush_i & (gnt_vec_s[l]
                            | ((state_r[l] == LANE_ACTIVE) & ~lane_release_i[l]));
        end
    end

    // Per-lane FSM, age watchdog, capture of itype/pc, and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                state_r[l] <= LANE_FREE;
                age_r[l]   <= '0;
                itype_r[l] <= '0;
                pc_r[l]    <= '0;
            end
            free_r    <= '1;
            busy_r    <= '0;
            timeout_r <= '0;
            occ_r     <= '0;
            full_r    <= 1'b0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (flush_i) begin
                    state_r[l] <= LANE_FREE;
                    age_r[l]   <= '0;
                end else begin
                    case (state_r[l])
                        LANE_FREE: begin
                            if (gnt_vec_s[l]) begin
                                state_r[l] <= LANE_ACTIVE;
                                age_r[l]   <= '0;
                                itype_r[l] <= alloc_itype_i;
                                pc_r[l]    <= alloc_pc_i;
                            end
                        end
                        LANE_ACTIVE: begin
                            if (lane_release_i[l]) begin
                                state_r[l] <= LANE_FREE;
                            end else if (age_r[l] == AGE_MAX) begin
                                state_r[l] <= LANE_RECLAIM;
                            end else begin
                                age_r[l] <= age_r[l] + AGE_W'(1);
                            end
                        end
                        LANE_RECLAIM: begin
                            state_r[l] <= LANE_FREE;
                        end
                        default: begin
                            state_r[l] <= LANE_FREE;
                            age_r[l]   <= '0;
                        end
                    endcase
                end
            end
            free_r    <= ~busy_nxt_s;
            busy_r    <= busy_nxt_s;
            timeout_r <= expire_s & {NUM_LANES{~flush_i}};
            occ_r     <= popcount(busy_nxt_s);
            full_r    <= &busy_nxt_s;
        end
    end

    // Flatten the per-lane itype/pc storage onto the output buses.
    always_comb begin
        lane_itype_o = '0;
        lane_pc_o    = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_itype_o[l*ITYPE_W +: ITYPE_W] = itype_r[l];
            lane_pc_o[l*VLEN +: VLEN]          = pc_r[l];
        end
    end

    assign alloc_gnt_o    = gnt_s;
    assign alloc_lane_o   = gnt_lane_s;
    assign alloc_full_o   = full_r;
    assign lane_busy_o    = busy_r;
    assign lane_timeout_o = timeout_r;
    assign occupancy_o    = occ_r;

endmodule
